// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory interface.
// Accepts load / store / fetch-and-add requests over valid/ready and
// returns one response per request. Only one transaction is ever in flight.
// read_data is the combinational return path from data_memory.
module load_store_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] read_data
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_FADD  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] tmp;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [DATA_W-1:0] sum;

  // Fetch-and-add result; the carry out is intentionally dropped.
  assign sum = tmp + data_q;

  // During WRITE the sum drives the bus directly (tmp is only valid once
  // ACCESS has ended); otherwise the registered value is held.
  assign write_data = (state == WRITE) ? sum : wdata_q;

  // Strobes are suppressed combinationally while reset is high so a reset
  // arriving mid-operation can never commit a partial write.
  assign mem_read  = mem_read_q  & ~reset;
  assign mem_write = mem_write_q & ~reset;

  // Main sequencer: state, captured request, memory strobes and response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
      address     <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tmp         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            addr_q    <= req_addr;
            data_q    <= req_data;
            req_ready <= 1'b0;
            if (req_op == OP_RSVD) begin
              resp_data  <= '0;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              resp_err <= 1'b0;
              address  <= req_addr;
              state    <= ACCESS;
              if (req_op == OP_STORE) begin
                mem_write_q <= 1'b1;
                wdata_q     <= req_data;
              end else begin
                mem_read_q  <= 1'b1;
              end
            end
          end
        end
        ACCESS: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          case (op_q)
            OP_LOAD: begin
              resp_data  <= read_data;
              resp_valid <= 1'b1;
              state      <= RESP;
            end
            OP_FADD: begin
              tmp         <= read_data;
              resp_data   <= read_data;
              mem_write_q <= 1'b1;
              state       <= WRITE;
            end
            default: begin
              resp_data  <= data_q;
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          endcase
        end
        WRITE: begin
          mem_write_q <= 1'b0;
          address     <= addr_q;
          wdata_q     <= sum;
          resp_valid  <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
